// File: rtl/note_lane_pkg.sv
// Shared types and default sizing for the note lane scroller.
// Holds the per-press judgement encoding and the default parameter values
// used by note_lane_scroller and lane_judge.
package note_lane_pkg;

  typedef enum logic [1:0] {
    J_NONE  = 2'd0,
    J_SCORE = 2'd1,
    J_NEAR  = 2'd2,
    J_MISS  = 2'd3
  } judge_e;

  localparam int DEF_LANES         = 4;
  localparam int DEF_LANE_W        = 4;
  localparam int DEF_ROWS          = 16;
  localparam int DEF_NOTE_H        = 2;
  localparam int DEF_SCROLL_PERIOD = 512;

endpackage

// File: rtl/lane_judge.sv
// Per-lane press detector, hit flag and judgement for one note lane.
// Latency: judgement pulses appear one cycle after the press / scroll edge.
// Ports: clk, RST (sync, active-high), key_i (button), step_i (scroll edge),
//        win_i (pre-shift pixels of rows 0..2*NOTE_H-1 of this lane),
//        score_o/near_o/miss_o (registered pulses), clr_o (comb: note judged).
module lane_judge
  import note_lane_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int NOTE_H = DEF_NOTE_H
) (
  input  logic                            clk,
  input  logic                            RST,
  input  logic                            key_i,
  input  logic                            step_i,
  input  logic [2*NOTE_H-1:0][LANE_W-1:0] win_i,
  output logic                            score_o,
  output logic                            near_o,
  output logic                            miss_o,
  output logic                            clr_o
);

  logic   key_q, hit_q, gone_q;
  logic   hit_d, gone_d;
  logic   score_q, near_q, miss_q;
  logic   press, full, any, roll_miss;
  judge_e jud;

  always_comb begin
    full  = &win_i[NOTE_H-1:0];
    any   = |win_i;
    // A press while the lane's note is already judged is swallowed silently.
    press = key_i & ~key_q & ~hit_q;
    if (!press)    jud = J_NONE;
    else if (full) jud = J_SCORE;
    else if (any)  jud = J_NEAR;
    else           jud = J_MISS;
    clr_o = (jud == J_SCORE) || (jud == J_NEAR);
    // gone_q marks a note that already produced its scroll-off miss, so a
    // multi-row note discarded over several steps reports only once.
    roll_miss = step_i & (|win_i[0]) & ~hit_q & ~gone_q & ~clr_o;
    hit_d  = clr_o ? 1'b1 : (any ? hit_q : 1'b0);
    gone_d = roll_miss ? 1'b1 : (any ? gone_q : 1'b0);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      key_q   <= 1'b1;  // a key held through reset is not a press
      hit_q   <= 1'b0;
      gone_q  <= 1'b0;
      score_q <= 1'b0;
      near_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      key_q   <= key_i;
      hit_q   <= hit_d;
      gone_q  <= gone_d;
      score_q <= (jud == J_SCORE);
      near_q  <= (jud == J_NEAR);
      // press miss and scroll-off miss on the same edge merge into one pulse
      miss_q  <= (jud == J_MISS) | roll_miss;
    end
  end

  assign score_o = score_q;
  assign near_o  = near_q;
  assign miss_o  = miss_q;

endmodule

// File: rtl/note_lane_scroller.sv
// Falling-note pixel matrix: scrolls one row down every SCROLL_PERIOD cycles,
// spawns notes at the top and judges per-lane key presses near the bottom.
// Ports: clk, RST (sync, active-high), key/spawn (per lane), RedPixels [row][col]
//        (registered), tick (step pulse), score/near/miss (per-lane pulses).
// Option: define NOTE_LANE_HIT_CLEAR_EN to erase a lane's hit window on SCORE/NEAR.
module note_lane_scroller
  import note_lane_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int LANE_W        = DEF_LANE_W,
  parameter int ROWS          = DEF_ROWS,
  parameter int NOTE_H        = DEF_NOTE_H,
  parameter int SCROLL_PERIOD = DEF_SCROLL_PERIOD
) (
  input  logic                                 clk,
  input  logic                                 RST,
  input  logic [LANES-1:0]                     key,
  input  logic [LANES-1:0]                     spawn,
  output logic [ROWS-1:0][LANES*LANE_W-1:0]    RedPixels,
  output logic                                 tick,
  output logic [LANES-1:0]                     score,
  output logic [LANES-1:0]                     near,
  output logic [LANES-1:0]                     miss
);

  localparam int          COLS    = LANES * LANE_W;
  localparam int          WIN     = 2 * NOTE_H;
  localparam int          CNT_W   = $clog2(SCROLL_PERIOD);
  localparam [CNT_W-1:0]  CNT_MAX = CNT_W'(SCROLL_PERIOD - 1);

  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0]           pix_q, pix_d;
  logic                                tick_q;
  logic                                step;
  logic [LANES-1:0][WIN-1:0][LANE_W-1:0] win;
  logic [LANES-1:0]                    clr;

  assign step  = (cnt_q == CNT_MAX);
  assign cnt_d = step ? '0 : cnt_q + 1'b1;

  // Judgement windows are taken from the pre-shift map.
  always_comb begin
    win = '0;
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < WIN; r++)
        win[l][r] = pix_q[r][l*LANE_W +: LANE_W];
  end

  // Shift first, then spawn, so a spawn on a step edge lands in the top rows.
  always_comb begin
    pix_d = pix_q;
    if (step) begin
      for (int r = 0; r < ROWS - 1; r++) pix_d[r] = pix_q[r+1];
      pix_d[ROWS-1] = '0;
    end
    for (int l = 0; l < LANES; l++)
      if (spawn[l])
        for (int r = ROWS - NOTE_H; r < ROWS; r++)
          pix_d[r][l*LANE_W +: LANE_W] = '1;
`ifdef NOTE_LANE_HIT_CLEAR_EN
    for (int l = 0; l < LANES; l++)
      if (clr[l])
        for (int r = 0; r < WIN; r++)
          pix_d[r][l*LANE_W +: LANE_W] = '0;
`endif
  end

`ifndef NOTE_LANE_HIT_CLEAR_EN
  logic unused_clr;
  assign unused_clr = ^clr;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q  <= '0;
      pix_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pix_q  <= pix_d;
      tick_q <= step;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      lane_judge #(
        .LANE_W (LANE_W),
        .NOTE_H (NOTE_H)
      ) u_judge (
        .clk     (clk),
        .RST     (RST),
        .key_i   (key[g]),
        .step_i  (step),
        .win_i   (win[g]),
        .score_o (score[g]),
        .near_o  (near[g]),
        .miss_o  (miss[g]),
        .clr_o   (clr[g])
      );
    end
  endgenerate

  assign RedPixels = pix_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed self-checking bench for note_lane_scroller (4 lanes x 4 cols, 16 rows,
// 2-row notes, 4-cycle scroll period).
module tb_note_lane_scroller;

  logic              clk;
  logic              RST;
  logic [3:0]        key;
  logic [3:0]        spawn;
  logic [15:0][15:0] RedPixels;
  logic              tick;
  logic [3:0]        score, near, miss;

  note_lane_scroller #(
    .LANES(4), .LANE_W(4), .ROWS(16), .NOTE_H(2), .SCROLL_PERIOD(4)
  ) dut (
    .clk(clk), .RST(RST), .key(key), .spawn(spawn), .RedPixels(RedPixels),
    .tick(tick), .score(score), .near(near), .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_score [4];
  int n_near  [4];
  int n_miss  [4];
  int n_tick;
  int n_any;

  logic [255:0] map_flat;
  assign map_flat = RedPixels;

  function automatic logic [255:0] lane_rows(input int lane, input int lo, input int hi);
    logic [255:0] m;
    m = '0;
    for (int r = lo; r <= hi; r++)
      for (int c = 0; c < 4; c++)
        m[r*16 + lane*4 + c] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    for (int l = 0; l < 4; l++) begin
      n_score[l] = 0; n_near[l] = 0; n_miss[l] = 0;
    end
    n_tick = 0;
    n_any  = 0;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      n_score[l] += int'(score[l]);
      n_near[l]  += int'(near[l]);
      n_miss[l]  += int'(miss[l]);
      n_any      += int'(score[l]) + int'(near[l]) + int'(miss[l]);
    end
    n_tick += int'(tick);
  endtask

  // Advance until n scroll steps have been applied; returns just after the step edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      do begin
        cyc();
        k++;
      end while (tick !== 1'b1 && k < 8);
      if (tick !== 1'b1) begin
        n_vec++;
        n_err++;
        $error("FAIL tick_timeout: observed no tick within %0d cycles, required tick", k);
      end
    end
  endtask

  initial begin
    RST = 1'b1; key = '0; spawn = '0;
    clr_counts();
    repeat (3) cyc();
    check("reset_map", map_flat, '0);
    check("reset_tick", tick, 1'b0);
    check("reset_pulses", {score, near, miss}, 12'h000);

    // Lane 0 note reaches the hit rows after 14 steps and scores.
    RST = 1'b0;
    spawn = 4'b0001;
    cyc();
    spawn = '0;
    check("spawn_l0_top", map_flat, lane_rows(0, 14, 15));
    wait_ticks(14);
    check("l0_at_bottom", map_flat, lane_rows(0, 0, 1));
    clr_counts();
    key = 4'b0001;
    cyc();
    check("l0_score_pulse", {score, near, miss}, 12'h100);
    cyc();
    check("l0_score_one_cycle", {score, near, miss}, 12'h000);
    key = '0;
    wait_ticks(3);
    check("l0_judged_no_miss", n_miss[0], 0);

    // Lane 2 pressed one row early: NEAR.
    spawn = 4'b0100;
    cyc();
    spawn = '0;
    wait_ticks(13);
    check("l2_rows_1_2", map_flat, lane_rows(2, 1, 2));
    clr_counts();
    key = 4'b0100;
    cyc();
    check("l2_near_pulse", {score, near, miss}, 12'h040);
    key = '0;
    wait_ticks(4);
    check("l2_near_no_miss", n_miss[2], 0);

    // Lane 2 unplayed: exactly one scroll-off miss, on the step dropping row 0.
    spawn = 4'b0100;
    cyc();
    spawn = '0;
    clr_counts();
    wait_ticks(14);
    check("l2_no_early_miss", n_miss[2], 0);
    wait_ticks(1);
    check("l2_scroll_miss_pulse", miss, 4'b0100);
    wait_ticks(1);
    repeat (2) cyc();
    check("l2_single_miss", n_miss[2], 1);
    check("l2_map_empty", map_flat, '0);

    // Empty lane 1 press: one MISS even with the key held 10 cycles.
    clr_counts();
    key = 4'b0010;
    cyc();
    check("l1_empty_miss", {score, near, miss}, 12'h002);
    repeat (9) cyc();
    check("l1_held_single_pulse", n_any, 1);
    key = '0;

    // Spawn on the same edge as a step: shift happens first.
    wait_ticks(1);
    repeat (3) cyc();
    spawn = 4'b0010;
    cyc();
    spawn = '0;
    check("coincident_tick", tick, 1'b1);
    check("coincident_rows_14_15", map_flat, lane_rows(1, 14, 15));
    wait_ticks(1);
    check("coincident_rows_13_14", map_flat, lane_rows(1, 13, 14));
    clr_counts();
    wait_ticks(15);
    check("l1_scrolled_off", map_flat, '0);
    check("l1_scroll_single_miss", n_miss[1], 1);

    // Lane 3 scores; the judged note must not raise a scroll-off miss.
    spawn = 4'b1000;
    cyc();
    spawn = '0;
    wait_ticks(14);
    check("l3_at_bottom", map_flat, lane_rows(3, 0, 1));
    clr_counts();
    key = 4'b1000;
    cyc();
    check("l3_score_pulse", {score, near, miss}, 12'h800);
`ifdef NOTE_LANE_HIT_CLEAR_EN
    check("l3_hit_cleared", map_flat, '0);
    key = '0;
`else
    check("l3_note_kept", map_flat, lane_rows(3, 0, 1));
    key = '0;
    cyc();
    key = 4'b1000;
    cyc();
    key = '0;
`endif
    wait_ticks(3);
    check("l3_counts_s100_n10_m1", n_score[3]*100 + n_near[3]*10 + n_miss[3], 100);

    // Reset mid-run with key 0 held: everything clears, no press after release.
    spawn = 4'b0001;
    key   = 4'b0001;
    cyc();
    spawn = '0;
    repeat (2) cyc();
    RST = 1'b1;
    cyc();
    check("midrst_map", map_flat, '0);
    check("midrst_tick", tick, 1'b0);
    check("midrst_pulses", {score, near, miss}, 12'h000);
    cyc();
    RST = 1'b0;
    clr_counts();
    repeat (3) cyc();
    check("post_rst_no_tick", n_tick, 0);
    cyc();
    check("post_rst_first_tick", tick, 1'b1);
    check("post_rst_no_press", n_any, 0);
    key = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_lane_scroller.md
NOTE_LANE_SCROLLER -- requirements
Module: note_lane_scroller

Interface
REQ-001 Parameter LANES, default 4: number of note lanes.
REQ-002 Parameter LANE_W, default 4: pixel columns per lane; total columns COLS = LANES*LANE_W.
REQ-003 Parameter ROWS, default 16: matrix rows; row ROWS-1 is the top (spawn edge), row 0 is the bottom (hit edge).
REQ-004 Parameter NOTE_H, default 2: note height in rows; legal range 1..ROWS/4.
REQ-005 Parameter SCROLL_PERIOD, default 512: clock cycles per one-row scroll step; minimum 2.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 RST  input  1  reset, synchronous, active-high.
REQ-008 key  input  LANES  per-lane player button, active-high, already synchronised.
REQ-009 spawn  input  LANES  per-lane note-spawn request, sampled each cycle.
REQ-010 RedPixels  output  ROWS x COLS  registered pixel map, [row][col], lane n owns columns n*LANE_W..n*LANE_W+LANE_W-1.
REQ-011 tick  output  1  one-cycle pulse in the cycle a scroll step is applied.
REQ-012 score, near, miss  output  LANES each  one-cycle judgement pulses per lane.

Function
REQ-013 Tick counter counts 0..SCROLL_PERIOD-1 and wraps to 0; the scroll step is applied on the edge where the count equals SCROLL_PERIOD-1.
REQ-014 On a scroll step, every row r in 0..ROWS-2 takes the contents of row r+1, row ROWS-1 clears, and row 0 contents are discarded.
REQ-015 spawn[n] high sets all LANE_W columns of lane n in rows ROWS-NOTE_H..ROWS-1; when spawn and a scroll step share an edge, the shift applies first, then spawn pixels are written.
REQ-016 Press event for lane n: key[n]=1 while its registered previous value is 0; only rising edges are judged.
REQ-017 Judgement uses the pre-shift pixel state of the press edge: SCORE if all rows 0..NOTE_H-1 of lane n are lit; otherwise NEAR if any pixel of lane n in rows 0..2*NOTE_H-1 is lit; otherwise MISS.
REQ-018 The corresponding output bit pulses high for exactly one cycle, in the cycle after the press edge; at most one of score/near/miss per lane is high per cycle.
REQ-019 Per-lane hit flag sets on SCORE or NEAR; while it is set, further presses on that lane are ignored, with no pulse.
REQ-020 The hit flag clears on the first edge where rows 0..2*NOTE_H-1 of that lane are all dark.
REQ-021 Scroll-off miss: when a scroll step discards a lit row-0 pixel of lane n while its hit flag is clear, miss[n] pulses once, even if several columns are lit.
REQ-022 A press miss and a scroll-off miss on the same lane and edge produce a single miss pulse.
REQ-023 Lanes are independent; simultaneous presses on several lanes each produce their own pulse in the same cycle.
REQ-024 tick is high in the cycle following the step edge, coincident with the shifted map.

Reset
REQ-025 While RST is high at an edge: RedPixels, tick counter, hit flags, tick, score, near and miss all clear to 0.
REQ-026 While RST is high, the key history register loads all ones, so a key held through reset produces no press.
REQ-027 Reset asserted mid-scroll or mid-judgement discards all pending work; the first step after release occurs SCROLL_PERIOD cycles later.

Configuration
REQ-028 Macro NOTE_LANE_HIT_CLEAR_EN defined: a SCORE or NEAR on lane n also clears lane n rows 0..2*NOTE_H-1 at the same edge.
REQ-029 Without NOTE_LANE_HIT_CLEAR_EN, judged notes keep scrolling off and are suppressed from scroll-off miss only by the hit flag.

Structure
REQ-030 Package note_lane_pkg holds the judgement enum (J_NONE, J_SCORE, J_NEAR, J_MISS) and default parameter constants.
REQ-031 The per-lane edge detect, hit flag and judgement logic lives in sub-module lane_judge, instantiated LANES times via generate; scrolling and the tick counter stay in the top level.

Verification
Bench parameters: LANES=4, LANE_W=4, ROWS=16, NOTE_H=2, SCROLL_PERIOD=4.
REQ-032 Spawn on lane 0 for one cycle, then 14 steps -> rows 0..1 columns 0..3 lit; key[0] rise -> score[0] one cycle.
REQ-033 Spawn on lane 2, press after 13 steps (rows 1..2 lit) -> near[2]; with no press, after 16 steps -> single miss[2] on the step discarding row 0.
REQ-034 Empty matrix, key[1] rise -> miss[1]; key held high 10 cycles -> exactly one pulse.
REQ-035 Spawn coincident with a step edge -> rows 14..15 lit after that edge, rows 13..14 after the next step.
REQ-036 Press and score on lane 3, then the note scrolls off -> no miss[3]; with NOTE_LANE_HIT_CLEAR_EN -> lane 3 rows 0..3 dark the cycle after the press.
REQ-037 Assert RST mid-run with key[0] held -> all outputs 0; release -> no press pulse and no tick for 4 cycles.
